// File: rtl/minipit_host_if.sv
// minipit_host request port: period/mode programming handshake.
// The host accepts a request when req_valid and req_ready are both high.
interface minipit_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_period;
  logic        req_divider;
  logic        req_repeat;

  modport master (
    output req_valid,
    output req_period,
    output req_divider,
    output req_repeat,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_period,
    input  req_divider,
    input  req_repeat,
    output req_ready
  );
endinterface

// File: rtl/minipit_host.sv
// minipit_host: resets, programs and monitors one minipit timer.
// Define MINIPIT_HOST_VERIFY_EN to add the counter_set check and ERR state.
module minipit_host #(
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  minipit_host_if.slave  req,
  input  logic           stop,
  output logic           tmr_rst_n,
  output logic [7:0]     cfg_data,
  output logic [7:0]     cfg_ctrl,
  input  logic           irq_in,
  input  logic [7:0]     status_in,
  output logic           busy,
  output logic [7:0]     tick_count,
  output logic           overflow,
  output logic           irq_pulse,
  output logic           error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST0,
    S_RST1,
    S_CFG,
    S_HI,
    S_LO,
    S_VERIFY,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] per_q;
  logic        div_q;
  logic        rep_q;
  logic        irq_q;

  logic        accept;
  logic        stop_hit;
  logic        irq_edge;
  logic        count_en;
  logic        in_rst;

  logic        trst_d;
  logic [7:0]  cdata_d;
  logic [7:0]  cctrl_d;

  // Only counter_set matters; the rest of the status byte is ignored.
  logic        unused_status;
  assign unused_status = ^{status_in[7], status_in[5:0]};

  always_comb begin
    req.req_ready = 1'b0;
    busy          = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE),
      (state_q == S_RUN),
      (state_q == S_ERR): req.req_ready = 1'b1;
      default:            busy          = 1'b1;
    endcase
  end

  assign stop_hit = stop && (state_q != S_IDLE);
  assign accept   = req.req_valid && req.req_ready && !stop;
  assign in_rst   = (state_q == S_RST0) || (state_q == S_RST1);
  assign irq_edge = irq_in && !irq_q;
  assign count_en = (state_q == S_RUN) && irq_edge
                    && !accept && !stop_hit;

`ifdef MINIPIT_HOST_VERIFY_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          cs_seen;

  assign cs_seen = status_in[6];
`else
  logic unused_cs;
  assign unused_cs = status_in[6];
`endif

  always_comb begin
    state_d = state_q;
`ifdef MINIPIT_HOST_VERIFY_EN
    tmo_d   = tmo_q;
`endif
    if (stop_hit) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = S_RST0;
    end else begin
      unique case (state_q)
        S_RST0: state_d = S_RST1;
        S_RST1: state_d = S_CFG;
        S_CFG:  state_d = S_HI;
        S_HI:   state_d = S_LO;
`ifdef MINIPIT_HOST_VERIFY_EN
        S_LO: begin
          state_d = S_VERIFY;
          tmo_d   = '0;
        end
        S_VERIFY: begin
          if (cs_seen) begin
            state_d = S_RUN;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
`else
        S_LO:   state_d = S_RUN;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Pin values are decoded from the next state so they line up with it.
  always_comb begin
    trst_d  = 1'b1;
    cdata_d = 8'h00;
    cctrl_d = 8'h00;
    unique case (1'b1)
      (state_d == S_IDLE),
      (state_d == S_RST0),
      (state_d == S_RST1): trst_d = 1'b0;
      (state_d == S_CFG): begin
        cctrl_d = 8'h80;
        cdata_d = {div_q, rep_q, 6'b0};
      end
      (state_d == S_HI): begin
        cctrl_d = 8'hC0;
        cdata_d = per_q[15:8];
      end
      (state_d == S_LO): begin
        cctrl_d = 8'hA0;
        cdata_d = per_q[7:0];
      end
      default: trst_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      div_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        per_q <= req.req_period;
        div_q <= req.req_divider;
        rep_q <= req.req_repeat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_rst_n <= 1'b0;
      cfg_data  <= 8'h00;
      cfg_ctrl  <= 8'h00;
    end else begin
      tmr_rst_n <= trst_d;
      cfg_data  <= cdata_d;
      cfg_ctrl  <= cctrl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q      <= 1'b0;
      tick_count <= 8'h00;
      overflow   <= 1'b0;
      irq_pulse  <= 1'b0;
    end else begin
      irq_q     <= in_rst ? 1'b0 : irq_in;
      irq_pulse <= count_en;
      if (accept) begin
        tick_count <= 8'h00;
        overflow   <= 1'b0;
      end else if (count_en) begin
        tick_count <= tick_count + 8'h01;
        if (tick_count == 8'hFF) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef MINIPIT_HOST_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      error <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (accept) begin
        error <= 1'b0;
      end else if (state_d == S_ERR) begin
        error <= 1'b1;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_minipit_host.sv
// Directed bench for minipit_host with a tiny counter_set timer model.
// Build with MINIPIT_HOST_VERIFY_EN to also exercise VERIFY/ERR.
module tb_minipit_host;

  logic       clk;
  logic       rst_n;
  logic       stop;
  logic       tmr_rst_n;
  logic [7:0] cfg_data;
  logic [7:0] cfg_ctrl;
  logic       irq_in;
  logic [7:0] status_in;
  logic       busy;
  logic [7:0] tick_count;
  logic       overflow;
  logic       irq_pulse;
  logic       error;

  logic       cs;
  logic       block_cs;

  int n_cmp = 0;
  int n_bad = 0;

  minipit_host_if rq ();

  minipit_host #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (rq),
    .stop       (stop),
    .tmr_rst_n  (tmr_rst_n),
    .cfg_data   (cfg_data),
    .cfg_ctrl   (cfg_ctrl),
    .irq_in     (irq_in),
    .status_in  (status_in),
    .busy       (busy),
    .tick_count (tick_count),
    .overflow   (overflow),
    .irq_pulse  (irq_pulse),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer stand-in: counter_set rises on the edge that takes the LO write.
  always @(posedge clk) begin
    if (!tmr_rst_n) cs <= 1'b0;
    else if (cfg_ctrl == 8'hA0) cs <= 1'b1;
  end
  assign status_in = {1'b0, cs & ~block_cs, 6'b0};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p,
                      input logic d,
                      input logic r);
    rq.req_period  = p;
    rq.req_divider = d;
    rq.req_repeat  = r;
    rq.req_valid   = 1'b1;
    step();
    rq.req_valid   = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] exp, input bit check);
    irq_in = 1'b1;
    step();
    if (check) begin
      chk("irq_pulse_hi", irq_pulse, 1'b1);
      chk("tick", tick_count, exp);
    end
    irq_in = 1'b0;
    step();
    if (check) chk("irq_pulse_lo", irq_pulse, 1'b0);
  endtask

  task automatic to_run();
`ifdef MINIPIT_HOST_VERIFY_EN
    step(6);
`else
    step(5);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    stop           = 1'b0;
    irq_in         = 1'b0;
    block_cs       = 1'b0;
    rq.req_valid   = 1'b0;
    rq.req_period  = 16'h0;
    rq.req_divider = 1'b0;
    rq.req_repeat  = 1'b0;
    step(2);
    chk("rst_trst", tmr_rst_n, 1'b0);
    chk("rst_ctrl", cfg_ctrl, 8'h00);
    chk("rst_data", cfg_data, 8'h00);
    chk("rst_ready", rq.req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tick", tick_count, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_err", error, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic programming sequence, period 5, repeat mode
    send(16'h0005, 1'b0, 1'b1);
    chk("t1_trst", tmr_rst_n, 1'b0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", rq.req_ready, 1'b0);
    step();
    chk("t2_trst", tmr_rst_n, 1'b0);
    step();
    chk("t3_ctrl", cfg_ctrl, 8'h80);
    chk("t3_data", cfg_data, 8'h40);
    chk("t3_trst", tmr_rst_n, 1'b1);
    step();
    chk("t4_ctrl", cfg_ctrl, 8'hC0);
    chk("t4_data", cfg_data, 8'h00);
    step();
    chk("t5_ctrl", cfg_ctrl, 8'hA0);
    chk("t5_data", cfg_data, 8'h05);
    step();
    chk("t6_ctrl", cfg_ctrl, 8'h00);
    chk("t6_data", cfg_data, 8'h00);
`ifdef MINIPIT_HOST_VERIFY_EN
    chk("t6_busy", busy, 1'b1);
    step();
    chk("t7_busy", busy, 1'b0);
    chk("t7_ready", rq.req_ready, 1'b1);
`else
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", rq.req_ready, 1'b1);
`endif
    pulse(8'd1, 1'b1);
    pulse(8'd2, 1'b1);

    // Wrap
    for (int i = 0; i < 253; i++) pulse(8'd0, 1'b0);
    chk("wrap_ff", tick_count, 8'hFF);
    chk("wrap_ovf0", overflow, 1'b0);
    pulse(8'h00, 1'b1);
    chk("wrap_ovf1", overflow, 1'b1);
    pulse(8'h01, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);

    // stop beats req_valid
    stop           = 1'b1;
    rq.req_valid   = 1'b1;
    rq.req_period  = 16'h1234;
    step();
    stop           = 1'b0;
    rq.req_valid   = 1'b0;
    chk("stop_trst", tmr_rst_n, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_ready", rq.req_ready, 1'b1);
    chk("stop_tick", tick_count, 8'h01);
    chk("stop_ovf", overflow, 1'b1);
    step(3);
    chk("stop_idle_ctrl", cfg_ctrl, 8'h00);
    chk("stop_idle_busy", busy, 1'b0);

    // Divider set, then request racing an irq edge
    send(16'h0102, 1'b1, 1'b0);
    chk("t2_tick_clr", tick_count, 8'h00);
    chk("t2_ovf_clr", overflow, 1'b0);
    step(2);
    chk("t2_cfg_data", cfg_data, 8'h80);
    step(2);
    chk("t2_lo_data", cfg_data, 8'h02);
    to_run();
    chk("t2_run_busy", busy, 1'b0);
    pulse(8'd1, 1'b1);
    rq.req_valid = 1'b1;
    irq_in       = 1'b1;
    step();
    rq.req_valid = 1'b0;
    chk("race_tick", tick_count, 8'h00);
    chk("race_pulse", irq_pulse, 1'b0);
    chk("race_busy", busy, 1'b1);
    chk("race_trst", tmr_rst_n, 1'b0);
    irq_in = 1'b0;
    step();
    chk("race_pulse2", irq_pulse, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;

`ifdef MINIPIT_HOST_VERIFY_EN
    // counter_set never comes back
    block_cs = 1'b1;
    send(16'h0010, 1'b0, 1'b0);
    step(19);
    chk("tmo_t20_busy", busy, 1'b1);
    chk("tmo_t20_err", error, 1'b0);
    step();
    chk("tmo_err", error, 1'b1);
    chk("tmo_ready", rq.req_ready, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_trst", tmr_rst_n, 1'b1);
    step(2);
    chk("tmo_err_hold", error, 1'b1);
    block_cs = 1'b0;
    send(16'h0010, 1'b0, 1'b0);
    chk("tmo_err_clr", error, 1'b0);
    chk("tmo_rebusy", busy, 1'b1);
    step(6);
    chk("tmo_run", busy, 1'b0);
    chk("tmo_run_err", error, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
`endif

    // Async reset in the middle of HI
    send(16'h5555, 1'b0, 1'b0);
    step(3);
    chk("ar_hi_ctrl", cfg_ctrl, 8'hC0);
    chk("ar_hi_data", cfg_data, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ctrl", cfg_ctrl, 8'h00);
    chk("ar_data", cfg_data, 8'h00);
    chk("ar_trst", tmr_rst_n, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_ready", rq.req_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step(3);
    chk("ar_idle_ctrl", cfg_ctrl, 8'h00);
    chk("ar_idle_busy", busy, 1'b0);
    chk("ar_idle_trst", tmr_rst_n, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
